rf_wb_scheduler: RTL
====================

# rf_wb_scheduler

- Shares the single write port of the 64-bit integer register file between two write-back sources:
  - the in-order pipeline write-back from MEM3_WB;
  - the multi-cycle multiply/divide unit (MDU), through a valid/ready result handshake.
- Keeps a scoreboard of registers with MDU results still pending, and stalls decode on RAW/WAW hazards against them.
- Sits between MEM3_WB, the MDU and the register file. Drives the file's write-valid, write-address and data-in inputs.

## Interface
Parameters:
- XLEN, 64, data width
- STARVE_LIMIT, 8, cycles an MDU result may be refused before the pipeline is held (min 2)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- PIPE_WB_VALID  in  1  pipeline write-back valid (cannot be back-pressured)
- PIPE_WB_RD  in  5  pipeline destination register
- PIPE_WB_DATA  in  XLEN  pipeline write-back data
- MDU_ISSUE  in  1  MDU op dispatched this cycle; legal only when HAZARD_STALL=0
- MDU_ISSUE_RD  in  5  destination of the dispatched MDU op
- MDU_RES_VALID  in  1  MDU result available; held until accepted
- MDU_RES_RD  in  5  MDU result destination
- MDU_RES_DATA  in  XLEN  MDU result data
- MDU_RES_READY  out  1  MDU result accepted this cycle
- DEC_RS1_SEL, DEC_RS2_SEL  in  5 each  decode source registers
- DEC_RD_SEL  in  5  decode destination register
- DEC_RD_VALID  in  1  decode instruction writes DEC_RD_SEL
- HAZARD_STALL  out  1  hold decode this cycle
- PIPE_HOLD  out  1  request to insert one write-back bubble
- RF_WE  out  1  register-file write enable
- RF_WA  out  5  register-file write address
- RF_WD  out  XLEN  register-file write data

## Operation
- Scoreboard:
  - BUSY[31:1] is registered and all zero at reset; x0 is never busy.
  - MDU_ISSUE with MDU_ISSUE_RD≠0 sets BUSY[rd] at the next edge.
  - An accepted MDU result with rd≠0 clears BUSY[rd] at the next edge.
  - If a set and a clear hit the same rd in the same cycle, the set wins.
- HAZARD_STALL (combinational) = BUSY[DEC_RS1_SEL] | BUSY[DEC_RS2_SEL] | (DEC_RD_VALID & BUSY[DEC_RD_SEL]).
  - Covers RAW and WAW hazards.
  - There is no bypass. The stall drops the cycle after the MDU write.
- Port arbitration (combinational), pipeline has fixed priority:
  - A pipeline write to x0 does not occupy the port. pipe_use = PIPE_WB_VALID & (PIPE_WB_RD≠0).
  - MDU_RES_READY = MDU_RES_VALID & !pipe_use.
  - RF_WE = pipe_use | (MDU_RES_READY & MDU_RES_RD≠0).
  - RF_WA/RF_WD come from the pipeline when pipe_use, otherwise from the MDU.
  - With RF_WE=0, RF_WA and RF_WD are 0.
- An MDU result to x0 is accepted with RF_WE=0.
- RST mid-operation: BUSY, the wait counter and PIPE_HOLD clear at the edge. In-flight MDU results are dropped; the MDU is reset by the same RST.

## Timing
- Write path: zero latency, combinational from inputs to RF_*. The register file commits at the same rising edge.
- Handshake: transfer occurs on a cycle with MDU_RES_VALID & MDU_RES_READY. The MDU keeps RD and DATA stable while valid and not ready.
- Scoreboard: MDU_ISSUE in cycle N sets BUSY, so HAZARD_STALL for that rd is seen in cycle N+1.
- Result: a result written in cycle M clears BUSY, so the stall is low in M+1 and the read returns the new value.
- Reset values: MDU_RES_READY=0, HAZARD_STALL=0, PIPE_HOLD=0, RF_WE=0, RF_WA=0, RF_WD=0.
  - Combinational outputs hold these values whenever the inputs are idle.

## Configuration
- RF_WB_STARVE_GUARD_EN defined:
  - WAIT_CNT counts consecutive cycles with MDU_RES_VALID & !MDU_RES_READY.
  - WAIT_CNT clears on acceptance, when valid drops, or on reset.
  - When WAIT_CNT reaches STARVE_LIMIT-1 and the result is still refused, PIPE_HOLD is registered high for exactly one cycle and WAIT_CNT clears.
  - The pipeline guarantees PIPE_WB_VALID=0 in the cycle after PIPE_HOLD, so the MDU is accepted in that cycle.
- Undefined: no counter, PIPE_HOLD tied 0. The MDU relies on natural pipeline bubbles to be accepted.

## Structure
- Shared pipeline package holds:
  - XLEN;
  - the REG_ADDR_W=5 constant;
  - a wb_req_t typedef (valid, rd, data) used for both sources.
- One sub-module, rf_scoreboard: BUSY bits, set/clear, three-port hazard lookup.
- Arbitration and the starvation guard live in the top module.

## Test plan
- Reset, then MDU_ISSUE rd=5 → BUSY[5]=1 next cycle. Decode with RS1=5 → HAZARD_STALL=1.
- MDU result rd=5, data=0x1234, no pipe traffic → RF_WE=1, RF_WA=5, RF_WD=0x1234 and MDU_RES_READY=1 in the same cycle; HAZARD_STALL=0 the next cycle.
- Pipe write rd=7 data=0xAA and MDU result valid in the same cycle → RF_WA=7, RF_WD=0xAA, READY=0. Pipe rd=0 with MDU valid → MDU granted.
- MDU_ISSUE rd=9 in the same cycle as an accepted result rd=9 → BUSY[9] stays 1.
- With RF_WB_STARVE_GUARD_EN, STARVE_LIMIT=8: pipe writes rd=3 every cycle with MDU valid:
  - PIPE_HOLD=1 in cycle 9 after valid rose;
  - the bench drops the pipe write → MDU accepted in cycle 10.
- RST asserted while BUSY[4]=1 and an MDU result is pending → all outputs 0, BUSY cleared the next cycle.

Source files
------------

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared write-back types and constants for the integer register-file write port.
// Imported by rf_scoreboard and rf_wb_scheduler.
package rf_wb_scheduler_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // One write-back request; the same shape serves the pipeline and the MDU.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 is hard-wired zero, so it never takes the port or a scoreboard bit.
  function automatic logic is_real_rd(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-MDU-result scoreboard: one busy bit per architectural register
// plus a three-port hazard lookup for the decode stage.
module rf_scoreboard
  import rf_wb_scheduler_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  rd_valid_i,
  output logic                  hazard_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_rd_i] = 1'b0;
    // Set is applied after clear so a same-cycle reissue keeps the bit busy.
    if (set_i) busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, so it is just the highest-priority branch of the clocked block.
  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign hazard_o = busy_q[rs1_i] | busy_q[rs2_i] | (rd_valid_i & busy_q[rd_i]);

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter between pipeline write-back and the MDU,
// with a pending-result scoreboard. Optional starvation guard: RF_WB_STARVE_GUARD_EN.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int XLEN         = rf_wb_scheduler_pkg::XLEN,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PIPE_WB_VALID,
  input  logic [REG_ADDR_W-1:0] PIPE_WB_RD,
  input  logic [XLEN-1:0]       PIPE_WB_DATA,
  input  logic                  MDU_ISSUE,
  input  logic [REG_ADDR_W-1:0] MDU_ISSUE_RD,
  input  logic                  MDU_RES_VALID,
  input  logic [REG_ADDR_W-1:0] MDU_RES_RD,
  input  logic [XLEN-1:0]       MDU_RES_DATA,
  output logic                  MDU_RES_READY,
  input  logic [REG_ADDR_W-1:0] DEC_RS1_SEL,
  input  logic [REG_ADDR_W-1:0] DEC_RS2_SEL,
  input  logic [REG_ADDR_W-1:0] DEC_RD_SEL,
  input  logic                  DEC_RD_VALID,
  output logic                  HAZARD_STALL,
  output logic                  PIPE_HOLD,
  output logic                  RF_WE,
  output logic [REG_ADDR_W-1:0] RF_WA,
  output logic [XLEN-1:0]       RF_WD
);

  wb_req_t pipe_req;
  wb_req_t mdu_req;
  wb_req_t wr_req;
  logic    pipe_use;
  logic    mdu_accept;

  assign pipe_use   = PIPE_WB_VALID & is_real_rd(PIPE_WB_RD);
  assign mdu_accept = MDU_RES_VALID & ~pipe_use;

  assign pipe_req = '{valid: pipe_use, rd: PIPE_WB_RD, data: PIPE_WB_DATA};
  assign mdu_req  = '{valid: mdu_accept & is_real_rd(MDU_RES_RD),
                      rd: MDU_RES_RD, data: MDU_RES_DATA};

  // Pipeline has fixed priority; an idle port drives all-zero address/data.
  always_comb begin
    wr_req = '0;
    if (pipe_req.valid)     wr_req = pipe_req;
    else if (mdu_req.valid) wr_req = mdu_req;
  end

  assign MDU_RES_READY = mdu_accept;
  assign RF_WE         = wr_req.valid;
  assign RF_WA         = wr_req.rd;
  assign RF_WD         = wr_req.data;

  rf_scoreboard u_scoreboard (
    .clk_i      (CLK),
    .rst_i      (RST),
    .set_i      (MDU_ISSUE),
    .set_rd_i   (MDU_ISSUE_RD),
    .clr_i      (mdu_accept),
    .clr_rd_i   (MDU_RES_RD),
    .rs1_i      (DEC_RS1_SEL),
    .rs2_i      (DEC_RS2_SEL),
    .rd_i       (DEC_RD_SEL),
    .rd_valid_i (DEC_RD_VALID),
    .hazard_o   (HAZARD_STALL)
  );

`ifdef RF_WB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             hold_q;
  logic             hold_d;
  logic             refused;

  assign refused = MDU_RES_VALID & ~mdu_accept;

  // Count consecutive refusals; on the last allowed one request a single bubble.
  always_comb begin
    wait_cnt_d = '0;
    hold_d     = 1'b0;
    if (refused) begin
      if (wait_cnt_q == CNT_LAST) hold_d     = 1'b1;
      else                        wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign PIPE_HOLD = hold_q;
`else
  // Guard compiled out; the MDU waits for natural pipeline bubbles.
  assign PIPE_HOLD = 1'b0 && (STARVE_LIMIT >= 2);
`endif

endmodule
